alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_pkg.sv | 27 ++
 rtl/alu_arbiter_rr_pick2.sv | 28 ++
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter: FSM state
// encodings, the highest legal ALU opcode, the registered operation
// bundle and an opcode legality helper.
package alu_arbiter_pkg;

  // FSM state encodings (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Opcodes 0..10 are ADD..RSH, MUL, DIV, MOD; 11..15 are unassigned.
  localparam logic [3:0] AXIS_CPU_MAX_OP = 4'd10;

  // Operation bundle latched at grant and presented to the ALU.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
  } alu_op_t;

  function automatic logic is_legal_op(input logic [3:0] sel);
    return (sel <= AXIS_CPU_MAX_OP);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// alu_arbiter_rr_pick2 (rr_pick2)
// Two-way round-robin picker. The pointer names the preferred requester;
// if it is idle the other requester wins. Purely combinational.
// Ports:
//   vld_i   [1:0] request valids
//   ptr_i         preferred requester index
//   grant_o [1:0] one-hot grant (zero when nobody requests)
module alu_arbiter_rr_pick2 (
  input  logic [1:0] vld_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  logic other;
  assign other = ~ptr_i;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else leaves it unassigned and infers a latch.
  always_comb begin
    grant_o = 2'b00;
    if (vld_i[ptr_i]) begin
      grant_o[ptr_i] = 1'b1;
    end else if (vld_i[other]) begin
      grant_o[other] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one multi-cycle ALU between two requesters. One operation is in
// flight at a time: IDLE grants a requester (round-robin on contention),
// ISSUE pulses ALU_en, WAIT captures the ALU result, RESP holds the result
// for the winner until it acknowledges. Illegal opcodes skip the ALU and
// answer immediately with err set.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   reqN_vld/A/B/sel, reqN_rdy    request channel per requester (N=0,1)
//   respN_vld/out/flags/err/ack   response channel per requester
//   A, B, ALU_sel, ALU_en         operation issued to the ALU
//   ALU_out, set, eq, gt, ge      ALU result and compare flags
//   ALU_vld, ALU_ack              ALU result handshake (vld sticky until ack)
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [3:0]  req0_sel,
  output logic        req0_rdy,
  input  logic        req1_vld,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [3:0]  req1_sel,
  output logic        req1_rdy,
  output logic        resp0_vld,
  output logic [31:0] resp0_out,
  output logic [3:0]  resp0_flags,
  output logic        resp0_err,
  input  logic        resp0_ack,
  output logic        resp1_vld,
  output logic [31:0] resp1_out,
  output logic [3:0]  resp1_flags,
  output logic        resp1_err,
  input  logic        resp1_ack,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ALU_sel,
  output logic        ALU_en,
  input  logic [31:0] ALU_out,
  input  logic        set,
  input  logic        eq,
  input  logic        gt,
  input  logic        ge,
  input  logic        ALU_vld,
  output logic        ALU_ack
);

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;      // preferred requester for next contention
  logic        win_q, win_d;      // requester owning the in-flight op
  alu_op_t     op_q, op_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d;
  logic        err_q, err_d;

  logic [1:0]  grant;
  alu_op_t     gnt_op;
  logic        winner_ack;

  alu_arbiter_rr_pick2 u_pick (
    .vld_i   ({req1_vld, req0_vld}),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign gnt_op     = grant[1] ? {req1_A, req1_B, req1_sel}
                               : {req0_A, req0_B, req0_sel};
  assign winner_ack = win_q ? resp1_ack : resp0_ack;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          win_d = grant[1];
          ptr_d = ~grant[1];
          if (is_legal_op(gnt_op.sel)) begin
            // ALU-facing operands only change for ops the ALU will run.
            op_d    = gnt_op;
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            res_d   = '0;
            flags_d = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ALU_vld) begin
          res_d   = ALU_out;
          flags_d = {set, eq, gt, ge};
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (winner_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its pre-edge value regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  // rdy and ALU_ack must react within the cycle; gating with rst keeps them
  // low while reset is being applied.
  assign req0_rdy = rst & (state_q == ST_IDLE) & grant[0];
  assign req1_rdy = rst & (state_q == ST_IDLE) & grant[1];
  // A result seen in IDLE is stale (e.g. left over from an abandoned op):
  // consume it without capturing.
  assign ALU_ack  = rst & ALU_vld & ((state_q == ST_WAIT) || (state_q == ST_IDLE));
  assign ALU_en   = (state_q == ST_ISSUE);

  assign A       = op_q.a;
  assign B       = op_q.b;
  assign ALU_sel = op_q.sel;

  assign resp0_vld   = (state_q == ST_RESP) & ~win_q;
  assign resp1_vld   = (state_q == ST_RESP) &  win_q;
  assign resp0_err   = resp0_vld & err_q;
  assign resp1_err   = resp1_vld & err_q;
  assign resp0_out   = res_q;
  assign resp1_out   = res_q;
  assign resp0_flags = flags_q;
  assign resp1_flags = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MOD = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_vld = 1'b0, req1_vld = 1'b0;
  logic [31:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic [3:0]  req0_sel = '0, req1_sel = '0;
  logic        req0_rdy, req1_rdy;
  logic        resp0_vld, resp1_vld, resp0_err, resp1_err;
  logic [31:0] resp0_out, resp1_out;
  logic [3:0]  resp0_flags, resp1_flags;
  logic        resp0_ack = 1'b0, resp1_ack = 1'b0;
  logic [31:0] A, B;
  logic [3:0]  ALU_sel;
  logic        ALU_en, ALU_ack;
  logic [31:0] ALU_out = '0;
  logic        set = 1'b0, eq = 1'b0, gt = 1'b0, ge = 1'b0;
  logic        ALU_vld = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_A(req0_A), .req0_B(req0_B), .req0_sel(req0_sel), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_A(req1_A), .req1_B(req1_B), .req1_sel(req1_sel), .req1_rdy(req1_rdy),
    .resp0_vld(resp0_vld), .resp0_out(resp0_out), .resp0_flags(resp0_flags), .resp0_err(resp0_err), .resp0_ack(resp0_ack),
    .resp1_vld(resp1_vld), .resp1_out(resp1_out), .resp1_flags(resp1_flags), .resp1_err(resp1_err), .resp1_ack(resp1_ack),
    .A(A), .B(B), .ALU_sel(ALU_sel), .ALU_en(ALU_en),
    .ALU_out(ALU_out), .set(set), .eq(eq), .gt(gt), .ge(ge),
    .ALU_vld(ALU_vld), .ALU_ack(ALU_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural ALU ----------------
  // Samples handshake mid-cycle, updates 1 time unit after the rising edge.
  // Latency from ALU_en cycle to ALU_vld: 1 (simple ops), 5 (MUL), 20 (DIV/MOD).
  logic        en_s = 1'b0, ack_s = 1'b0, rst_s = 1'b0;
  logic [31:0] a_s = '0, b_s = '0;
  logic [3:0]  sel_s = '0;
  int          remain = 0;
  logic [31:0] res_m = '0;
  logic [3:0]  flg_m = '0;
  int          stale_cnt = 0;
  int          stale_seen = 0;

  always @(negedge clk) begin
    #2;
    en_s = ALU_en; ack_s = ALU_ack; rst_s = rst;
    a_s = A; b_s = B; sel_s = ALU_sel;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_s) begin
      ALU_vld = 1'b0;
      remain  = 0;
    end else begin
      if (ack_s) ALU_vld = 1'b0;
      if (stale_cnt != stale_seen) begin
        stale_seen = stale_cnt;
        ALU_vld = 1'b1;
        ALU_out = 32'hDEAD_BEEF;
      end
      if (en_s) begin
        case (sel_s)
          OP_ADD:  res_m = a_s + b_s;
          OP_MUL:  res_m = a_s * b_s;
          OP_DIV:  res_m = a_s / b_s;
          OP_MOD:  res_m = a_s % b_s;
          default: res_m = 32'd0;
        endcase
        flg_m  = {a_s < b_s, a_s == b_s, a_s > b_s, a_s >= b_s};
        remain = (sel_s == OP_MUL) ? 5 : ((sel_s == OP_DIV || sel_s == OP_MOD) ? 20 : 1);
      end
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          ALU_vld = 1'b1;
          ALU_out = res_m;
          {set, eq, gt, ge} = flg_m;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel);
    if (n == 0) begin req0_vld = v; req0_A = a; req0_B = b; req0_sel = sel; end
    else        begin req1_vld = v; req1_A = a; req1_B = b; req1_sel = sel; end
  endtask

  function automatic logic rdy_of(input int n);
    return (n == 0) ? req0_rdy : req1_rdy;
  endfunction

  function automatic logic rvld_of(input int n);
    return (n == 0) ? resp0_vld : resp1_vld;
  endfunction

  // Issue one op and follow it to its response; returns observations only.
  task automatic issue_and_wait(input int n, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] sel, output int t0, output int en_cnt,
                                output int en_cyc, output int rcyc, output bit stable, output bit to);
    t0 = -1; en_cnt = 0; en_cyc = -1; rcyc = -1; stable = 1'b1; to = 1'b0;
    @(posedge clk); #1; drive_req(n, 1'b1, a, b, sel);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy_of(n)) begin t0 = cyc; break; end
    end
    @(posedge clk); #1; drive_req(n, 1'b0, a, b, sel);
    if (t0 < 0) begin to = 1'b1; return; end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ALU_en) begin en_cnt++; if (en_cyc < 0) en_cyc = cyc; end
      if (en_cyc >= 0 && (A !== a || B !== b || ALU_sel !== sel)) stable = 1'b0;
      if (rvld_of(n)) begin rcyc = cyc; break; end
    end
    if (rcyc < 0) to = 1'b1;
  endtask

  task automatic do_ack(input int n);
    @(posedge clk); #1;
    if (n == 0) resp0_ack = 1'b1; else resp1_ack = 1'b1;
    @(posedge clk); #1;
    resp0_ack = 1'b0; resp1_ack = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 60 && !rvld_of(n); i++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({req0_rdy, req1_rdy, resp0_vld, resp1_vld, ALU_en, ALU_ack, resp0_err, resp1_err} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000000",
        {req0_rdy, req1_rdy, resp0_vld, resp1_vld, ALU_en, ALU_ack, resp0_err, resp1_err}); end
    total++; if ({A, B, ALU_sel} !== 68'h0) begin
      bad++; $display("FAIL reset_alu_ops: got A=%h B=%h sel=%h want 0", A, B, ALU_sel); end
    total++; if ({resp0_out, resp0_flags, resp1_out, resp1_flags} !== 72'h0) begin
      bad++; $display("FAIL reset_resp_data: got %h/%h want 0", resp0_out, resp0_flags); end
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_round_robin;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'd1, 32'd2, OP_ADD);
    drive_req(1, 1'b1, 32'd3, 32'd4, OP_ADD);
    @(negedge clk);
    total++; if ({req0_rdy, req1_rdy} !== 2'b10) begin
      bad++; $display("FAIL rr_first: got rdy0/1=%b want 10", {req0_rdy, req1_rdy}); end
    @(posedge clk); #1; req0_vld = 1'b0;
    wait_resp(0);
    total++; if (resp0_vld !== 1'b1 || resp0_out !== 32'd3) begin
      bad++; $display("FAIL rr_resp0: got vld=%b out=%0d want 1/3", resp0_vld, resp0_out); end
    @(posedge clk); #1; resp0_ack = 1'b1;
    @(negedge clk);
    total++; if (req1_rdy !== 1'b0) begin
      bad++; $display("FAIL rr_no_grant_in_ack: got %b want 0", req1_rdy); end
    @(posedge clk); #1; resp0_ack = 1'b0;
    @(negedge clk);
    total++; if (req1_rdy !== 1'b1) begin
      bad++; $display("FAIL rr_second: got req1_rdy=%b want 1", req1_rdy); end
    @(posedge clk); #1; req1_vld = 1'b0;
    wait_resp(1);
    total++; if (resp1_vld !== 1'b1 || resp1_out !== 32'd7) begin
      bad++; $display("FAIL rr_resp1: got vld=%b out=%0d want 1/7", resp1_vld, resp1_out); end
    do_ack(1);
    // Third simultaneous pair: pointer is back on requester 0.
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'd10, 32'd20, OP_ADD);
    drive_req(1, 1'b1, 32'd30, 32'd40, OP_ADD);
    @(negedge clk);
    total++; if ({req0_rdy, req1_rdy} !== 2'b10) begin
      bad++; $display("FAIL rr_third: got rdy0/1=%b want 10", {req0_rdy, req1_rdy}); end
    @(posedge clk); #1; req0_vld = 1'b0;
    wait_resp(0);
    total++; if (resp0_out !== 32'd30) begin
      bad++; $display("FAIL rr_resp0b: got %0d want 30", resp0_out); end
    do_ack(0);
    for (int i = 0; i < 10 && !req1_rdy; i++) @(negedge clk);
    @(posedge clk); #1; req1_vld = 1'b0;
    wait_resp(1);
    total++; if (resp1_vld !== 1'b1 || resp1_out !== 32'd70) begin
      bad++; $display("FAIL rr_resp1b: got vld=%b out=%0d want 1/70", resp1_vld, resp1_out); end
    do_ack(1);
  endtask

  task automatic test_add;
    int t0, en_cnt, en_cyc, rcyc; bit stable, to;
    issue_and_wait(0, 32'd5, 32'd7, OP_ADD, t0, en_cnt, en_cyc, rcyc, stable, to);
    total++; if (to) begin bad++; $display("FAIL add_timeout: got timeout want response"); end
    total++; if (en_cyc != t0 + 1 || en_cnt != 1) begin
      bad++; $display("FAIL add_en: got en at T+%0d count %0d want T+1 count 1", en_cyc - t0, en_cnt); end
    total++; if (rcyc != t0 + 3) begin
      bad++; $display("FAIL add_lat: got T+%0d want T+3", rcyc - t0); end
    total++; if (resp0_out !== 32'd12 || resp0_flags !== 4'b1000 || resp0_err !== 1'b0 || resp1_vld !== 1'b0) begin
      bad++; $display("FAIL add_result: got out=%0d flags=%b err=%b r1=%b want 12 1000 0 0",
                      resp0_out, resp0_flags, resp0_err, resp1_vld); end
    // Ack from the wrong requester must not release the held result.
    @(posedge clk); #1; resp1_ack = 1'b1;
    @(posedge clk); #1; resp1_ack = 1'b0;
    @(negedge clk);
    total++; if (resp0_vld !== 1'b1 || resp0_out !== 32'd12) begin
      bad++; $display("FAIL add_hold: got vld=%b out=%0d want 1/12", resp0_vld, resp0_out); end
    do_ack(0);
    @(negedge clk);
    total++; if (resp0_vld !== 1'b0) begin
      bad++; $display("FAIL add_release: got vld=%b want 0", resp0_vld); end
  endtask

  task automatic test_mul;
    int t0, en_cnt, en_cyc, rcyc; bit stable, to;
    issue_and_wait(1, 32'h0001_0000, 32'h10, OP_MUL, t0, en_cnt, en_cyc, rcyc, stable, to);
    total++; if (to || rcyc != t0 + 7) begin
      bad++; $display("FAIL mul_lat: got T+%0d timeout=%b want T+7", rcyc - t0, to); end
    total++; if (resp1_out !== 32'h0010_0000 || resp1_flags !== 4'b0011 || resp0_vld !== 1'b0) begin
      bad++; $display("FAIL mul_result: got %h flags=%b r0=%b want 00100000 0011 0", resp1_out, resp1_flags, resp0_vld); end
    total++; if (!stable || en_cnt != 1) begin
      bad++; $display("FAIL mul_stable: got stable=%b en_count=%0d want 1/1", stable, en_cnt); end
    do_ack(1);
  endtask

  task automatic test_divmod;
    int t0, en_cnt, en_cyc, rcyc; bit stable, to;
    issue_and_wait(0, 32'd100, 32'd7, OP_DIV, t0, en_cnt, en_cyc, rcyc, stable, to);
    total++; if (to || rcyc != t0 + 22 || en_cnt != 1) begin
      bad++; $display("FAIL div_lat: got T+%0d en_count=%0d want T+22 1", rcyc - t0, en_cnt); end
    total++; if (resp0_out !== 32'd14 || resp0_flags !== 4'b0011) begin
      bad++; $display("FAIL div_result: got %0d flags=%b want 14 0011", resp0_out, resp0_flags); end
    do_ack(0);
    issue_and_wait(0, 32'd100, 32'd7, OP_MOD, t0, en_cnt, en_cyc, rcyc, stable, to);
    total++; if (to || resp0_out !== 32'd2 || en_cnt != 1 || !stable) begin
      bad++; $display("FAIL mod_result: got %0d en_count=%0d stable=%b want 2 1 1", resp0_out, en_cnt, stable); end
    do_ack(0);
  endtask

  task automatic test_illegal;
    int t0, en_cnt, en_cyc, rcyc; bit stable, to;
    issue_and_wait(1, 32'd9, 32'd9, 4'd13, t0, en_cnt, en_cyc, rcyc, stable, to);
    total++; if (to || rcyc != t0 + 1) begin
      bad++; $display("FAIL illegal_lat: got T+%0d want T+1", rcyc - t0); end
    total++; if (resp1_err !== 1'b1 || resp1_out !== 32'd0 || resp1_flags !== 4'd0) begin
      bad++; $display("FAIL illegal_resp: got err=%b out=%0d flags=%b want 1 0 0000", resp1_err, resp1_out, resp1_flags); end
    total++; if (en_cnt != 0 || ALU_sel === 4'd13) begin
      bad++; $display("FAIL illegal_alu: got en_count=%0d sel=%0d want 0 and sel!=13", en_cnt, ALU_sel); end
    do_ack(1);
  endtask

  task automatic test_stale;
    int t0, en_cnt, en_cyc, rcyc; bit stable, to;
    @(negedge clk); stale_cnt++;
    @(negedge clk);
    total++; if (ALU_vld !== 1'b1 || ALU_ack !== 1'b1 || ALU_en !== 1'b0) begin
      bad++; $display("FAIL stale_ack: got vld=%b ack=%b en=%b want 1 1 0", ALU_vld, ALU_ack, ALU_en); end
    @(negedge clk);
    total++; if (ALU_vld !== 1'b0 || resp0_vld !== 1'b0 || resp1_vld !== 1'b0) begin
      bad++; $display("FAIL stale_noresp: got alu_vld=%b r0=%b r1=%b want 0 0 0", ALU_vld, resp0_vld, resp1_vld); end
    issue_and_wait(0, 32'd1, 32'd1, OP_ADD, t0, en_cnt, en_cyc, rcyc, stable, to);
    total++; if (to || rcyc != t0 + 3 || resp0_out !== 32'd2 || resp0_flags !== 4'b0101) begin
      bad++; $display("FAIL stale_next: got T+%0d out=%h flags=%b want T+3 2 0101", rcyc - t0, resp0_out, resp0_flags); end
    do_ack(0);
  endtask

  task automatic test_drop;
    int rdy1_seen = 0;
    int en_seen = 0;
    @(posedge clk); #1; drive_req(0, 1'b1, 32'd50, 32'd5, OP_DIV);
    for (int i = 0; i < 10 && !req0_rdy; i++) @(negedge clk);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 32'd0, 32'd0, OP_ADD);
    drive_req(1, 1'b1, 32'd8, 32'd8, OP_ADD);
    repeat (3) begin @(negedge clk); if (req1_rdy) rdy1_seen++; end
    @(posedge clk); #1; req1_vld = 1'b0;
    wait_resp(0);
    total++; if (resp0_vld !== 1'b1 || resp0_out !== 32'd10) begin
      bad++; $display("FAIL drop_busy_resp: got vld=%b out=%0d want 1/10", resp0_vld, resp0_out); end
    do_ack(0);
    repeat (5) begin @(negedge clk); if (req1_rdy) rdy1_seen++; if (ALU_en) en_seen++; end
    total++; if (rdy1_seen != 0 || en_seen != 0) begin
      bad++; $display("FAIL drop_no_grant: got rdy1=%0d en=%0d want 0 0", rdy1_seen, en_seen); end
  endtask

  task automatic test_reset_mid;
    int t0 = -1;
    int rcyc = -1;
    @(posedge clk); #1; drive_req(0, 1'b1, 32'd100, 32'd7, OP_DIV);
    for (int i = 0; i < 10 && !req0_rdy; i++) @(negedge clk);
    @(posedge clk); #1; req0_vld = 1'b0;
    repeat (4) @(negedge clk);   // op is now in WAIT
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++; if ({req0_rdy, req1_rdy, resp0_vld, resp1_vld, ALU_en, ALU_ack, resp0_err, resp1_err} !== 8'h00
                 || {A, B, ALU_sel} !== 68'h0 || resp0_out !== 32'd0 || resp0_flags !== 4'd0) begin
      bad++; $display("FAIL rst_mid_outputs: got ctrl=%b A=%h B=%h sel=%h out=%h want all 0",
        {req0_rdy, req1_rdy, resp0_vld, resp1_vld, ALU_en, ALU_ack, resp0_err, resp1_err}, A, B, ALU_sel, resp0_out); end
    @(posedge clk); #1;
    rst = 1'b1;
    drive_req(0, 1'b1, 32'd2, 32'd2, OP_ADD);
    @(negedge clk);
    total++; if (req0_rdy !== 1'b1) begin
      bad++; $display("FAIL rst_first_cycle: got rdy=%b want 1", req0_rdy); end
    t0 = cyc;
    @(posedge clk); #1; req0_vld = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((resp0_vld || resp1_vld) && rcyc < 0) rcyc = cyc;
    end
    total++; if (rcyc != t0 + 3 || resp0_out !== 32'd4) begin
      bad++; $display("FAIL rst_abandon: got first resp at T+%0d out=%0d want T+3 4", rcyc - t0, resp0_out); end
    do_ack(0);
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_add;
    test_mul;
    test_divmod;
    test_illegal;
    test_stale;
    test_drop;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
